ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive-side companion to the team's N-bit one-hot ring counter. It samples the ring bus each clock, decodes the hot position to a binary index, and checks two things: that the bus is a legal one-hot code, and that it advances in legal rotation order.
- It also counts completed revolutions.
- Used as a bus monitor/decoder wherever a ring-counter output drives downstream logic.

Parameters:
- N, 3, ring width in bits (N >= 2).
- IDX_W, $clog2(N), width of the decoded index.
- CNT_W, 8, width of the revolution counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ring_in  input  N  ring-counter bus under decode
- en  input  1  sample enable; when 0, ring_in is ignored
- clr_err  input  1  synchronous clear of the sticky error flags
- idx  output  IDX_W  binary position of the hot bit
- valid  output  1  idx is trustworthy (FSM locked, last sample legal)
- onehot_err  output  1  sticky: an illegal code (zero or multi-hot) was sampled
- seq_err  output  1  sticky: a legal code arrived out of rotation order
- rev_pulse  output  1  one-cycle pulse on each wrap from bit N-1 to bit 0
- rev_count  output  CNT_W  revolutions since reset, modulo 2^CNT_W

Behaviour:
- Reset: rst_n=0 asynchronously forces the following. Reset is fully asynchronous; deassertion is taken on a clk edge.
  - idx=0, valid=0, onehot_err=0, seq_err=0, rev_pulse=0, rev_count=0
  - FSM=SYNC, internal prev register=0
- Reset mid-operation behaves identically: lock, counts and flags are all lost.
- Legal rotation: the successor of prev is rotate-left, {prev[N-2:0], prev[N-1]}. For N=3 the order is 001->010->100->001.
- Latency: all outputs are registered. ring_in sampled at edge k is reflected on outputs after edge k, i.e. 1 cycle.
- en=0: FSM, prev, idx, valid and counters hold; rev_pulse=0; no error detection.
- Legal one-hot check: ring_in != 0 and (ring_in & (ring_in-1)) == 0.
- FSM state SYNC, on each enabled cycle:
  - Legal sample: prev<=sample, idx<=encoded position, valid<=1, go to TRACK. No revolution is counted on entry.
  - Illegal sample: onehot_err<=1, valid<=0, stay in SYNC.
- FSM state TRACK, on each enabled cycle:
  - sample==prev (stalled source): hold idx, valid stays 1, no error.
  - sample==successor(prev): prev<=sample, idx updates, valid=1. If prev[N-1]=1 and sample[0]=1, then rev_pulse<=1 and rev_count<=rev_count+1, wrapping to 0 at 2^CNT_W-1.
  - Other legal one-hot (skip or backward step): seq_err<=1, valid<=0, go to SYNC. No revolution is counted.
  - Illegal sample: onehot_err<=1, valid<=0, go to SYNC.
- After dropping to SYNC, the next legal sample relocks without error and on the same edge as it is sampled.
- clr_err=1 clears onehot_err and seq_err on the next edge. If a new error is detected in the same cycle, set wins and the flag stays 1. clr_err does not affect FSM, idx, valid or rev_count.
- Both error types coincide only in the sense that an illegal code is always classified as onehot_err, never as seq_err.
- Index encoding: idx = position of the single 1, with bit0 mapping to 0. idx is only updated on legal samples.

Test Plan:
1. Reset-then-run: rst_n=0 for 2 cycles, then ring_in cycling 001,010,100,001,010 with en=1.
   -> valid=1 from the first sample; idx=0,1,2,0,1; one rev_pulse on the 100->001 step; rev_count=1; no error flags.
2. Illegal codes: while locked at 010, drive 000, then 011, then 100.
   -> onehot_err=1 and valid=0 on both bad samples; the FSM relocks on 100 with idx=2 and valid=1; seq_err stays 0.
3. Sequence violation: locked at 001, drive 100 (a skip).
   -> seq_err=1, valid=0; the next sample 001 relocks with idx=0; rev_count unchanged.
4. Stall and enable: hold ring_in=010 for 4 cycles, then pulse en=0 while ring_in jumps to 001, then en=1 with ring_in=100.
   -> no errors, idx=1 throughout the hold; the en=0 cycle is ignored; 100 accepted as the successor with idx=2.
5. Wrap and clear: run 256 full revolutions with CNT_W=8; separately assert clr_err in the same cycle as an illegal sample, then again with a legal sample.
   -> rev_count returns to 0 after 256 revolutions; onehot_err stays 1 on the first clear and clears to 0 on the second.
6. Async reset mid-run: drop rst_n between clock edges at rev_count=5 with errors set.
   -> all outputs are 0 immediately, before the next edge; the FSM relocks on the first legal sample after release.

Source files
------------

// File: rtl/ring_decoder.sv
// Ring-counter bus monitor: decodes the hot bit to a binary index, flags
// illegal codes and out-of-order steps, and counts completed revolutions.
module ring_decoder #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     ring_in,
  input  logic             en,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             rev_pulse,
  output logic [CNT_W-1:0] rev_count
);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t           state;
  logic [N-1:0]     prev;
  logic             legal;
  logic [N-1:0]     succ;
  logic [IDX_W-1:0] enc;

  always_comb begin
    legal = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
    succ  = {prev[N-2:0], prev[N-1]};
    enc   = '0;
    for (int unsigned i = 0; i < N; i++)
      if (ring_in[i]) enc = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      prev       <= '0;
      idx        <= '0;
      valid      <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      rev_pulse  <= 1'b0;
      rev_count  <= '0;
    end else begin
      rev_pulse <= 1'b0;
      // Clear first so that a detection later in this block overrides it.
      if (clr_err) begin
        onehot_err <= 1'b0;
        seq_err    <= 1'b0;
      end
      if (en) begin
        unique case (state)
          SYNC: begin
            if (legal) begin
              prev  <= ring_in;
              idx   <= enc;
              valid <= 1'b1;
              state <= TRACK;
            end else begin
              onehot_err <= 1'b1;
              valid      <= 1'b0;
            end
          end
          TRACK: begin
            if (!legal) begin
              onehot_err <= 1'b1;
              valid      <= 1'b0;
              state      <= SYNC;
            end else if (ring_in == prev) begin
              valid <= 1'b1;
            end else if (ring_in == succ) begin
              prev  <= ring_in;
              idx   <= enc;
              valid <= 1'b1;
              if (prev[N-1] && ring_in[0]) begin
                rev_pulse <= 1'b1;
                rev_count <= rev_count + CNT_W'(1);
              end
            end else begin
              seq_err <= 1'b1;
              valid   <= 1'b0;
              state   <= SYNC;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: position-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ring_decoder;

  localparam int N     = 3;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     ring_in = '0;
  logic             en = 1'b0;
  logic             clr_err = 1'b0;
  logic [IDX_W-1:0] idx;
  logic             valid, onehot_err, seq_err, rev_pulse;
  logic [CNT_W-1:0] rev_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  ring_decoder #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .en(en), .clr_err(clr_err),
    .idx(idx), .valid(valid), .onehot_err(onehot_err), .seq_err(seq_err),
    .rev_pulse(rev_pulse), .rev_count(rev_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the hot position as an integer.
  bit m_locked;
  int m_pos, m_idx, m_valid, m_oh, m_seq, m_pulse, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0; m_pos = 0; m_idx = 0; m_valid = 0;
      m_oh = 0; m_seq = 0; m_pulse = 0; m_cnt = 0;
    end else begin
      int p;
      bit lg;
      m_pulse = 0;
      if (clr_err) begin m_oh = 0; m_seq = 0; end
      if (en) begin
        lg = ($countones(ring_in) == 1);
        p = 0;
        for (int i = 0; i < N; i++) if (ring_in[i]) p = i;
        if (!lg) begin
          m_oh = 1; m_valid = 0; m_locked = 0;
        end else if (!m_locked) begin
          m_locked = 1; m_pos = p; m_idx = p; m_valid = 1;
        end else if (p == m_pos) begin
          m_valid = 1;
        end else if (p == (m_pos + 1) % N) begin
          if (m_pos == N - 1 && p == 0) begin
            m_pulse = 1;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
          end
          m_pos = p; m_idx = p; m_valid = 1;
        end else begin
          m_seq = 1; m_valid = 0; m_locked = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("idx", int'(idx), m_idx);
    chk("valid", int'(valid), m_valid);
    chk("onehot_err", int'(onehot_err), m_oh);
    chk("seq_err", int'(seq_err), m_seq);
    chk("rev_pulse", int'(rev_pulse), m_pulse);
    chk("rev_count", int'(rev_count), m_cnt);
    if (rev_pulse) pulses++;
  end

  task automatic cyc(input logic [N-1:0] r, input logic e, input logic c);
    ring_in = r; en = e; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] cur;

  initial begin
    // 1: reset then run
    do_reset();
    chk("t1_reset_valid", int'(valid), 0);
    chk("t1_reset_cnt", int'(rev_count), 0);
    cyc(3'b001, 1, 0); chk("t1_idx0", int'(idx), 0); chk("t1_valid", int'(valid), 1);
    cyc(3'b010, 1, 0); chk("t1_idx1", int'(idx), 1);
    cyc(3'b100, 1, 0); chk("t1_idx2", int'(idx), 2);
    cyc(3'b001, 1, 0); chk("t1_pulse", int'(rev_pulse), 1); chk("t1_cnt", int'(rev_count), 1);
    cyc(3'b010, 1, 0); chk("t1_idx1b", int'(idx), 1); chk("t1_nopulse", int'(rev_pulse), 0);
    chk("t1_oh", int'(onehot_err), 0); chk("t1_seq", int'(seq_err), 0);

    // 2: illegal codes
    cyc(3'b000, 1, 0); chk("t2_oh", int'(onehot_err), 1); chk("t2_v0", int'(valid), 0);
    cyc(3'b011, 1, 0); chk("t2_v1", int'(valid), 0);
    cyc(3'b100, 1, 0); chk("t2_idx", int'(idx), 2); chk("t2_valid", int'(valid), 1);
    chk("t2_seq", int'(seq_err), 0);

    // 3: sequence violation
    cyc(3'b100, 1, 1); chk("t3_clr", int'(onehot_err), 0);
    cyc(3'b001, 1, 0); chk("t3_cnt_wrap", int'(rev_count), 2);
    cyc(3'b100, 1, 0); chk("t3_seq", int'(seq_err), 1); chk("t3_valid", int'(valid), 0);
    chk("t3_cnt_hold", int'(rev_count), 2);
    cyc(3'b001, 1, 0); chk("t3_idx", int'(idx), 0); chk("t3_relock", int'(valid), 1);
    chk("t3_cnt", int'(rev_count), 2);

    // 4: stall and enable
    cyc(3'b010, 1, 1); chk("t4_clr", int'(seq_err), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b010, 1, 0); chk("t4_hold_idx", int'(idx), 1); chk("t4_hold_seq", int'(seq_err), 0);
    end
    cyc(3'b001, 0, 0); chk("t4_en0_idx", int'(idx), 1); chk("t4_en0_valid", int'(valid), 1);
    cyc(3'b100, 1, 0); chk("t4_idx", int'(idx), 2); chk("t4_seq", int'(seq_err), 0);

    // 5: counter wrap and clear priority
    do_reset();
    cyc(3'b001, 1, 0);
    pulses = 0;
    for (int r = 0; r < 256; r++) begin
      cyc(3'b010, 1, 0); cyc(3'b100, 1, 0); cyc(3'b001, 1, 0);
    end
    @(negedge clk); #1;
    chk("t5_wrap_cnt", int'(rev_count), 0);
    chk("t5_pulses", pulses, 256);
    cyc(3'b000, 1, 1); chk("t5_set_wins", int'(onehot_err), 1);
    cyc(3'b010, 1, 1); chk("t5_cleared", int'(onehot_err), 0); chk("t5_idx", int'(idx), 1);

    // 6: async reset mid-run
    do_reset();
    cyc(3'b001, 1, 0);
    for (int r = 0; r < 5; r++) begin
      cyc(3'b010, 1, 0); cyc(3'b100, 1, 0); cyc(3'b001, 1, 0);
    end
    cyc(3'b100, 1, 0);
    cyc(3'b000, 1, 0);
    chk("t6_cnt5", int'(rev_count), 5);
    chk("t6_seq_set", int'(seq_err), 1);
    chk("t6_oh_set", int'(onehot_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_idx", int'(idx), 0); chk("t6_valid", int'(valid), 0);
    chk("t6_oh", int'(onehot_err), 0); chk("t6_seq", int'(seq_err), 0);
    chk("t6_pulse", int'(rev_pulse), 0); chk("t6_cnt", int'(rev_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3'b010, 1, 0); chk("t6_relock", int'(valid), 1); chk("t6_relock_idx", int'(idx), 1);

    // Randomized traffic
    cur = 3'b010;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(99);
      if (sel < 60)      cur = {cur[N-2:0], cur[N-1]};
      else if (sel < 75) cur = cur;
      else if (sel < 88) cur = N'(1) << $urandom_range(N-1);
      else               cur = N'($urandom_range((1 << N) - 1));
      cyc(cur, ($urandom_range(9) != 0), ($urandom_range(9) == 0));
      if ($countones(cur) != 1) cur = 3'b001;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
